// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, Status/Cause bit positions, ExcCodes, reset values.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;
    localparam int CA_IP_LO  = 8;
    localparam int CA_EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler; TI is sticky and set the cycle after an
// increment lands Count on Compare. Writing Compare clears TI, writing Count clears the prescaler.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int DW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

    logic [DW-1:0] r_div;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_ti;
    logic          r_inc;
    logic          w_wrap;

    assign w_wrap = (COUNT_DIV_LOG2 == 0) ? 1'b1 : (r_div == {DW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
            r_inc     <= 1'b0;
        end else begin
            if (we_count) begin
                r_count <= wdata;
                r_div   <= '0;
                r_inc   <= 1'b0;
            end else begin
                r_div <= w_wrap ? '0 : r_div + DW'(1);
                r_inc <= w_wrap;
                if (w_wrap)
                    r_count <= r_count + 32'd1;
            end
            if (we_compare)
                r_compare <= wdata;
            // A Compare write in the same cycle as a match wins and leaves TI low.
            if (we_compare)
                r_ti <= 1'b0;
            else if (r_inc && (r_count == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign count_o   = r_count;
    assign compare_o = r_compare;
    assign ti_o      = r_ti;

endmodule

// File: rtl/cp0_regfile_v2.sv
// CP0 register file at the commit point: MTC0/MFC0, timer, interrupt request,
// precise exception/ERET commit with combinational flush and redirect target.
module cp0_regfile_v2
    import cp0_pkg::*;
#(
    parameter int          HW_INT_W       = 6,
    parameter int          COUNT_DIV_LOG2 = 1,
    parameter bit          HAS_TIMER      = 1'b1,
    parameter logic [31:0] EXC_VEC        = 32'h0000_0100,
    parameter logic [31:0] INT_VEC        = 32'h0000_0040
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic                re,
    input  logic [4:0]          raddr,
    output logic [31:0]         rdata,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                exc_valid,
    input  logic [4:0]          exc_code,
    input  logic [31:0]         exc_pc,
    input  logic                exc_in_delay,
    input  logic [31:0]         exc_badvaddr,
    input  logic                eret,
    output logic                flush,
    output logic                flush_d,
    output logic [31:0]         redirect_pc,
    output logic                int_req,
    output logic                timer_int,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o
);

    logic [HW_INT_W-1:0] r_hwip;
    logic [1:0]          r_ip_sw;
    logic                r_bd;
    logic [4:0]          r_exc;
    logic [31:0]         r_epc;
    logic [31:0]         r_badv;
    logic [31:0]         r_status;
    logic                r_int_req;
    logic                r_flush_d;

    logic                w_mtc0;
    logic [31:0]         w_count;
    logic [31:0]         w_compare;
    logic                w_ti;
    logic [7:0]          w_ip;
    logic [31:0]         w_cause;
    logic                w_irq;

    // MTC0 only lands when no exception or ERET commits this cycle.
    assign w_mtc0 = we & ~exc_valid & ~eret;
    assign flush  = ~rst & (exc_valid | eret);

    generate
        if (HAS_TIMER) begin : g_timer
            cp0_timer #(.COUNT_DIV_LOG2(COUNT_DIV_LOG2)) u_timer (
                .clk        (clk),
                .rst        (rst),
                .we_count   (w_mtc0 && (waddr == REG_COUNT)),
                .we_compare (w_mtc0 && (waddr == REG_COMPARE)),
                .wdata      (wdata),
                .count_o    (w_count),
                .compare_o  (w_compare),
                .ti_o       (w_ti)
            );
        end else begin : g_no_timer
            assign w_count   = '0;
            assign w_compare = '0;
            assign w_ti      = 1'b0;
        end
    endgenerate

    always_comb begin
        w_ip                 = '0;
        w_ip[1:0]            = r_ip_sw;
        w_ip[2 +: HW_INT_W]  = r_hwip;
        w_ip[7]              = w_ip[7] | w_ti;
    end

    assign w_cause = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exc, 2'b0};
    assign w_irq   = r_status[ST_IE] & ~r_status[ST_EXL] & (|(w_ip & r_status[ST_IM_LO +: 8]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwip    <= '0;
            r_ip_sw   <= '0;
            r_bd      <= 1'b0;
            r_exc     <= '0;
            r_epc     <= '0;
            r_badv    <= '0;
            r_status  <= STATUS_RST;
            r_int_req <= 1'b0;
            r_flush_d <= 1'b0;
        end else begin
            r_hwip    <= hw_int;
            r_flush_d <= flush;
            // EXL only becomes visible after the flush edge, so suppress the request for that cycle.
            r_int_req <= flush ? 1'b0 : w_irq;
            if (exc_valid) begin
                if (!r_status[ST_EXL]) begin
                    r_epc <= exc_in_delay ? exc_pc - 32'd4 : exc_pc;
                    r_bd  <= exc_in_delay;
                end
                r_status[ST_EXL] <= 1'b1;
                r_exc            <= exc_code;
                if (is_addr_exc(exc_code))
                    r_badv <= exc_badvaddr;
            end else if (eret) begin
                r_status[ST_EXL] <= 1'b0;
            end else if (we) begin
                case (waddr)
                    REG_BADVADDR: r_badv   <= wdata;
                    REG_STATUS:   r_status <= wdata;
                    REG_CAUSE:    r_ip_sw  <= wdata[9:8];
                    REG_EPC:      r_epc    <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        redirect_pc = '0;
        if (flush) begin
            if (exc_valid)
                redirect_pc = (exc_code == EXC_INT) ? INT_VEC : EXC_VEC;
            else
                redirect_pc = (we && (waddr == REG_EPC)) ? wdata : r_epc;
        end
    end

    always_comb begin
        rdata = '0;
        if (re) begin
            case (raddr)
                REG_BADVADDR: rdata = r_badv;
                REG_COUNT:    rdata = w_count;
                REG_COMPARE:  rdata = w_compare;
                REG_STATUS:   rdata = r_status;
                REG_CAUSE:    rdata = w_cause;
                REG_EPC:      rdata = r_epc;
                default:      rdata = '0;
            endcase
        end
    end

    assign flush_d   = r_flush_d;
    assign int_req   = r_int_req;
    assign timer_int = w_ti;
    assign status_o  = r_status;
    assign cause_o   = w_cause;
    assign epc_o     = r_epc;

endmodule
